// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// MIPS opcode constants and the NOP word.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FS_REQ   = 2'd0,
        FS_WAIT  = 2'd1,
        FS_EXEC  = 2'd2,
        FS_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [5:0]  OP_RTYPE = 6'h00;
    localparam logic [5:0]  OP_LW    = 6'h23;
    localparam logic [5:0]  OP_SW    = 6'h2b;
    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_ADDI  = 6'h08;
    localparam logic [5:0]  OP_J     = 6'h02;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection for the instruction being retired:
// jump target beats taken branch, which beats sequential pc+4.
module next_pc_calc (
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_low,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] branch_off;

    assign branch_off = {{14{instr_low[15]}}, instr_low[15:0], 2'b00};

    always_comb begin
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr_low, 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end else begin
            next_pc = pc_plus4;
        end
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch: one instruction in flight, req/ready memory
// handshake, next-PC on retire, sticky fault on timeout or misaligned target.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Zero,
    output logic [31:0] instr_out,
    output logic [5:0]  opcode,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fault,
    output logic [31:0] retired_cnt
);

    fetch_state_e state, next_state;
    logic [31:0]  pc;
    logic [7:0]   wait_cnt;
    logic [31:0]  next_pc;
    logic         misaligned;

    next_pc_calc u_next_pc (
        .pc_plus4   (pc_plus4),
        .instr_low  (instr_out[25:0]),
        .jump       (Jump),
        .branch     (Branch),
        .zero       (Zero),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FS_REQ;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FS_REQ:   next_state = imem_ready ? FS_EXEC : FS_WAIT;
            FS_WAIT: begin
                if (imem_ready) begin
                    next_state = FS_EXEC;
                end else if (wait_cnt == TIMEOUT) begin
                    next_state = FS_FAULT;
                end
            end
            FS_EXEC: begin
                if (!stall) begin
                    next_state = misaligned ? FS_FAULT : FS_REQ;
                end
            end
            default:  next_state = FS_FAULT;
        endcase
    end

    // Request is suppressed during the reset cycle so an abandoned fetch is never re-issued.
    always_comb begin
        imem_req    = ((state == FS_REQ) || (state == FS_WAIT)) && !reset;
        instr_valid = (state == FS_EXEC);
        fault       = (state == FS_FAULT);
    end

    assign imem_addr = pc;
    assign opcode    = instr_out[31:26];
    assign pc_plus4  = pc_out + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr_out   <= NOP_WORD;
            pc_out      <= 32'd0;
            retired_cnt <= 32'd0;
            wait_cnt    <= 8'd0;
        end else begin
            case (state)
                FS_REQ, FS_WAIT: begin
                    if (imem_ready) begin
                        instr_out <= imem_rdata;
                        pc_out    <= pc;
                    end else begin
                        wait_cnt  <= (state == FS_REQ) ? 8'd1 : wait_cnt + 8'd1;
                    end
                end
                FS_EXEC: begin
                    if (!stall) begin
                        pc          <= next_pc;
                        retired_cnt <= retired_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// fetch/stall/branch traffic compared against a transaction-level PC model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] MIS_INSTR = 32'h1000_0003;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ready, stall, Jump, Branch, Zero;
    logic [31:0] imem_addr, imem_rdata, instr_out, pc_out, pc_plus4, retired_cnt;
    logic [5:0]  opcode;
    logic        instr_valid, fault;

    logic        mis_req, mis_vld, mis_fault;
    logic [31:0] mis_addr, mis_instr, mis_pc, mis_pc4, mis_ret;
    logic [5:0]  mis_op;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(8'd4)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
        .Jump(Jump), .Branch(Branch), .Zero(Zero), .instr_out(instr_out),
        .opcode(opcode), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .fault(fault), .retired_cnt(retired_cnt)
    );

    // Second instance starts at a misaligned PC so a taken branch yields a misaligned target.
    fetch_unit #(.RESET_PC(32'h0000_0002), .TIMEOUT(8'd4)) dut_mis (
        .clk(clk), .reset(reset), .imem_req(mis_req), .imem_addr(mis_addr),
        .imem_ready(1'b1), .imem_rdata(MIS_INSTR), .stall(1'b0),
        .Jump(1'b0), .Branch(1'b1), .Zero(1'b1), .instr_out(mis_instr),
        .opcode(mis_op), .pc_out(mis_pc), .pc_plus4(mis_pc4),
        .instr_valid(mis_vld), .fault(mis_fault), .retired_cnt(mis_ret)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input bit j, input bit b, input bit z);
        logic [31:0]        p4;
        logic signed [31:0] off;
        p4  = pc + 32'd4;
        off = $signed({{16{ins[15]}}, ins[15:0]});
        if (j) return (p4 & 32'hF000_0000) | ({6'b0, ins[25:0]} * 32'd4);
        if (b && z) return p4 + 32'(off * 4);
        return p4;
    endfunction

    function automatic logic [5:0] op_pick(input int i);
        case (i)
            0: return OP_RTYPE;
            1: return OP_LW;
            2: return OP_SW;
            3: return OP_BEQ;
            4: return OP_ADDI;
            default: return OP_J;
        endcase
    endfunction

    task automatic do_instr(input logic [31:0] ins, input int lat, input int stalls,
                            input bit j, input bit b, input bit z);
        chk("req", 32'(imem_req), 32'd1);
        chk("addr", imem_addr, m_pc);
        for (int k = 0; k < lat; k++) begin
            imem_ready = 1'b0;
            tick();
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, m_pc);
            chk("wait_vld", 32'(instr_valid), 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = ins;
        tick();
        imem_ready = 1'b0;
        imem_rdata = $urandom();
        chk("exec_vld", 32'(instr_valid), 32'd1);
        chk("exec_instr", instr_out, ins);
        chk("exec_op", 32'(opcode), 32'(ins[31:26]));
        chk("exec_pc", pc_out, m_pc);
        chk("exec_pc4", pc_plus4, m_pc + 32'd4);
        chk("exec_req", 32'(imem_req), 32'd0);
        chk("exec_ret", retired_cnt, m_ret);
        for (int s = 0; s < stalls; s++) begin
            stall      = 1'b1;
            Jump       = 1'($urandom_range(0, 1));
            Branch     = 1'($urandom_range(0, 1));
            Zero       = 1'($urandom_range(0, 1));
            imem_ready = 1'($urandom_range(0, 1));
            tick();
            chk("stall_vld", 32'(instr_valid), 32'd1);
            chk("stall_instr", instr_out, ins);
            chk("stall_pc", pc_out, m_pc);
            chk("stall_ret", retired_cnt, m_ret);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        stall      = 1'b0;
        Jump       = j;
        Branch     = b;
        Zero       = z;
        imem_ready = 1'b0;
        tick();
        m_pc  = ref_next(m_pc, ins, j, b, z);
        m_ret = m_ret + 32'd1;
        stall = 1'($urandom_range(0, 1));
        Jump  = 1'($urandom_range(0, 1));
        chk("ret_vld", 32'(instr_valid), 32'd0);
        chk("ret_cnt", retired_cnt, m_ret);
        chk("hold_instr", instr_out, ins);
        chk("ret_fault", 32'(fault), 32'd0);
    endtask

    initial begin
        logic [31:0] rnd;
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        stall = 1'b0; Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_vld", 32'(instr_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_ret", retired_cnt, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_pcout", pc_out, 32'd0);
        reset = 1'b0; imem_ready = 1'b0;
        #1;
        m_pc  = RST_PC;
        m_ret = 32'd0;

        // addi at 0, single-cycle memory, sequential retire
        do_instr(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("t1_opcode", 32'(instr_out[31:26]), 32'(6'b001000));
        chk("t1_addr", imem_addr, 32'h0000_0004);
        chk("t1_ret", retired_cnt, 32'd1);
        do_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0);
        do_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0);
        do_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0);
        // beq at 0x10, taken and not taken
        do_instr(32'h1000_0003, 0, 0, 1'b0, 1'b1, 1'b1);
        chk("t2_taken", imem_addr, 32'h0000_0020);
        do_instr(32'h0800_0004, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("t2_back", imem_addr, 32'h0000_0010);
        do_instr(32'h1000_0003, 0, 0, 1'b0, 1'b1, 1'b0);
        chk("t2_nottaken", imem_addr, 32'h0000_0014);
        // jumps, jump wins over a taken branch
        do_instr(32'h0810_0002, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("t3_far", imem_addr, 32'h0040_0008);
        do_instr(32'h0800_0010, 0, 0, 1'b1, 1'b1, 1'b1);
        chk("t3_jprio", imem_addr, 32'h0000_0040);
        // slow memory and long stall
        do_instr(32'h8C01_0004, 3, 5, 1'b0, 1'b0, 1'b0);
        chk("t4_addr", imem_addr, 32'h0000_0044);

        for (int n = 0; n < 40; n++) begin
            rnd = $urandom();
            rnd[31:26] = op_pick(int'($urandom_range(0, 5)));
            do_instr(rnd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end

        // memory never answers: TIMEOUT=4 allows five request cycles
        imem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("to_req", 32'(imem_req), 32'd1);
            chk("to_fault_early", 32'(fault), 32'd0);
            tick();
        end
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_req_off", 32'(imem_req), 32'd0);
        imem_ready = 1'b1;
        tick();
        tick();
        chk("to_sticky", 32'(fault), 32'd1);
        chk("to_vld", 32'(instr_valid), 32'd0);
        chk("to_req_off2", 32'(imem_req), 32'd0);

        // reset while waiting on a late memory response
        reset = 1'b1; imem_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("t6_wait_req", 32'(imem_req), 32'd1);
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t6_rst_req", 32'(imem_req), 32'd0);
        tick();
        reset = 1'b0; imem_ready = 1'b0;
        #1;
        chk("t6_vld", 32'(instr_valid), 32'd0);
        chk("t6_instr", instr_out, 32'd0);
        chk("t6_pcout", pc_out, 32'd0);
        chk("t6_fault", 32'(fault), 32'd0);
        chk("t6_addr", imem_addr, RST_PC);
        chk("t6_req", 32'(imem_req), 32'd1);

        // misaligned branch target on the second instance
        tick();
        chk("mis_vld", 32'(mis_vld), 32'd1);
        chk("mis_pc", mis_pc, 32'h0000_0002);
        tick();
        chk("mis_fault", 32'(mis_fault),
            32'((ref_next(32'h0000_0002, MIS_INSTR, 1'b0, 1'b1, 1'b1) & 32'h3) != 0));
        chk("mis_req", 32'(mis_req), 32'd0);
        chk("mis_ret", mis_ret, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
